cout_pair_gen: RTL and testbench
================================

COUT_PAIR_GEN -- requirements
Module: cout_pair_gen

Interface
REQ-001 The block SHALL have one clock CLK and an asynchronous active-low reset rst_n; no other clock or reset exists.
REQ-002 Ports SHALL be as follows:
- CLK  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to begin a sequence; sampled only in IDLE
- target  in  2  requested relation: 00 EQ, 01 A_LEAD, 10 B_LEAD, 11 treated as EQ
- period  in  10  cycles between ticks; values 0 and 1 clamped to 2
- hold_cnt  in  8  number of simultaneous A+B pulse pairs issued after the target is reached
- CoutA  out  1  one-cycle carry pulse, stream A
- CoutB  out  1  one-cycle carry pulse, stream B
- AeqB, AmB, BmA  out  1 each  one-hot tracked relation: equal, A ahead, B ahead
- busy  out  1  high in SEEK, HOLD and DONE
- done  out  1  one-cycle completion pulse

Function
REQ-003 On the start-sampling edge the block SHALL latch target, period (after clamping) and hold_cnt, clear the tick counter and enter SEEK; inputs SHALL be ignored until the next IDLE.
REQ-004 The 10-bit tick counter SHALL count 0..P-1 and wrap; a tick SHALL occur when it wraps, so ticks fall at P, 2P, 3P... cycles after the start edge.
REQ-005 CoutA and CoutB SHALL be registered, asserted only in the cycle following a tick, and high for exactly one cycle.
REQ-006 The relation tracker SHALL update one cycle after each pulse, as follows:
- A alone: EQ->A_LEAD, B_LEAD->EQ, A_LEAD stays A_LEAD
- B alone: EQ->B_LEAD, A_LEAD->EQ, B_LEAD stays B_LEAD
- A and B together: no change
REQ-007 In SEEK, on a tick where relation != target, the block SHALL emit one corrective pulse toward the target and stay in SEEK:
- CoutA when the target lies in the A direction
- CoutB otherwise
- A_LEAD<->B_LEAD therefore takes two ticks
REQ-008 In SEEK, on a tick where relation == target, the block SHALL emit no pulse, load the remaining count from hold_cnt and enter HOLD.
REQ-009 In HOLD, on each tick, the block SHALL:
- if remaining != 0: emit CoutA and CoutB together and decrement remaining
- if remaining == 0: enter DONE
REQ-010 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE; done SHALL be 0 in all other cycles.
REQ-011 The relation SHALL persist across sequences; a new start SHALL begin from the relation left by the previous sequence.
REQ-012 AeqB, AmB and BmA SHALL be registered and one-hot at all times.
REQ-013 start asserted while busy=1 SHALL have no effect.

Reset
REQ-014 While rst_n=0 the block SHALL hold the following, regardless of CLK:
- FSM in IDLE
- tick counter and remaining count at 0
- CoutA=CoutB=0, busy=0, done=0
- AeqB=1, AmB=0, BmA=0
REQ-015 Reset asserted mid-sequence SHALL abort the sequence immediately without issuing done; after release the block SHALL wait in IDLE for start.

Structure
REQ-016 A shared package SHALL hold:
- rel_t (EQ, A_LEAD, B_LEAD)
- ctl_state_t (IDLE, SEEK, HOLD, DONE)
- the constants PERIOD_MIN=2 and CNT_W=10
REQ-017 The relation tracker SHALL be one sub-module, rel_tracker (inputs CLK, rst_n, inA, inB; one-hot relation outputs), so that it can be reused as a checker.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset: hold rst_n=0 while driving start -> CoutA=CoutB=0, AeqB=1, busy=0, done=0 throughout.
- From EQ, start with target=01, period=4, hold_cnt=0 -> CoutA at t=5 only, AmB=1 from t=6, HOLD entered at tick t=8, done=1 at t=13, IDLE at t=14.
- From A_LEAD, target=10, period=2, hold_cnt=1 -> CoutB at t=3 and t=5 (relation EQ then B_LEAD), HOLD at tick t=6, CoutA=CoutB=1 at t=9, done at t=11.
- Clamp and ignore: period=0 gives ticks every 2 cycles; start re-pulsed in SEEK does not alter latched target or timing.
- Reset mid-HOLD with remaining=3 -> pulses stop at once, no done, AeqB=1, busy=0; a later start proceeds normally.
- target=11 from B_LEAD, period=3 -> single CoutA, relation EQ, then hold and done as for target=00.

Source files
------------

// File: rtl/cout_pair_gen_pkg.sv
// Shared types and constants for the carry-pair sequencer and its relation tracker.
package cout_pair_gen_pkg;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] PERIOD_MIN = 10'd2;

  // One-hot encoding so the tracker's state bits are the relation outputs.
  typedef enum logic [2:0] {
    EQ     = 3'b001,
    A_LEAD = 3'b010,
    B_LEAD = 3'b100
  } rel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } ctl_state_t;

  function automatic rel_t decode_target(input logic [1:0] t);
    rel_t r;
    case (t)
      2'b01:   r = A_LEAD;
      2'b10:   r = B_LEAD;
      default: r = EQ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cout_pair_gen_if.sv
// Request/status bundle between a sequence requester and cout_pair_gen.
interface cout_pair_gen_if;
  import cout_pair_gen_pkg::*;

  logic             start;
  logic [1:0]       target;
  logic [CNT_W-1:0] period;
  logic [7:0]       hold_cnt;
  logic             CoutA;
  logic             CoutB;
  logic             AeqB;
  logic             AmB;
  logic             BmA;
  logic             busy;
  logic             done;

  modport master (
    output start, target, period, hold_cnt,
    input  CoutA, CoutB, AeqB, AmB, BmA, busy, done
  );

  modport slave (
    input  start, target, period, hold_cnt,
    output CoutA, CoutB, AeqB, AmB, BmA, busy, done
  );

endinterface

// File: rtl/cout_pair_gen_rel_tracker.sv
// Tracks which carry stream is ahead; single pulses move the relation one step,
// coincident pulses cancel.
module rel_tracker
  import cout_pair_gen_pkg::*;
(
  input  logic CLK,
  input  logic rst_n,
  input  logic inA,
  input  logic inB,
  output logic AeqB,
  output logic AmB,
  output logic BmA
);

  rel_t rel_q;
  rel_t rel_d;

  always_comb begin
    rel_d = rel_q;
    if (inA && !inB) begin
      case (rel_q)
        EQ:      rel_d = A_LEAD;
        B_LEAD:  rel_d = EQ;
        default: rel_d = A_LEAD;
      endcase
    end else if (inB && !inA) begin
      case (rel_q)
        EQ:      rel_d = B_LEAD;
        A_LEAD:  rel_d = EQ;
        default: rel_d = B_LEAD;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rel_q <= EQ;
    end else begin
      rel_q <= rel_d;
    end
  end

  assign AeqB = rel_q[0];
  assign AmB  = rel_q[1];
  assign BmA  = rel_q[2];

endmodule

// File: rtl/cout_pair_gen.sv
// Carry-pair sequencer: steers the A/B relation to a target with single pulses
// on each tick, then issues a programmed number of simultaneous pairs.
//
// state | meaning
// IDLE  | waiting for start; relation held from the last sequence
// SEEK  | one corrective pulse per tick until relation matches target
// HOLD  | one A+B pair per tick until remaining count is exhausted
// DONE  | single-cycle completion, done=1
module cout_pair_gen
  import cout_pair_gen_pkg::*;
(
  input  logic            CLK,
  input  logic            rst_n,
  cout_pair_gen_if.slave  bus
);

  ctl_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  rel_t             tgt_q, tgt_d;
  logic [7:0]       hold_q, hold_d;
  logic [7:0]       rem_q, rem_d;
  logic             tick_q, tick_d;
  logic             cout_a_q, cout_a_d;
  logic             cout_b_q, cout_b_d;

  logic [2:0]       rel_vec;
  logic [CNT_W-1:0] per_clamped;
  logic             wrap;
  logic             toward_a;

  assign rel_vec     = {bus.BmA, bus.AmB, bus.AeqB};
  assign per_clamped = (bus.period < PERIOD_MIN) ? PERIOD_MIN : bus.period;
  assign wrap        = (cnt_q == per_q - 10'd1);
  // EQ is reached from B_LEAD by an A pulse, from A_LEAD by a B pulse.
  assign toward_a    = (tgt_q == A_LEAD) || ((tgt_q == EQ) && (rel_vec == B_LEAD));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    tgt_d    = tgt_q;
    hold_d   = hold_q;
    rem_d    = rem_q;
    tick_d   = 1'b0;
    cout_a_d = 1'b0;
    cout_b_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tgt_d   = decode_target(bus.target);
          per_d   = per_clamped;
          hold_d  = bus.hold_cnt;
          cnt_d   = '0;
          state_d = SEEK;
        end
      end
      SEEK, HOLD: begin
        cnt_d  = wrap ? '0 : cnt_q + 10'd1;
        tick_d = wrap;
        if (tick_q) begin
          if (state_q == SEEK) begin
            if (rel_vec == tgt_q) begin
              rem_d   = hold_q;
              state_d = HOLD;
            end else if (toward_a) begin
              cout_a_d = 1'b1;
            end else begin
              cout_b_d = 1'b1;
            end
          end else begin
            if (rem_q != 8'd0) begin
              cout_a_d = 1'b1;
              cout_b_d = 1'b1;
              rem_d    = rem_q - 8'd1;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      per_q    <= PERIOD_MIN;
      tgt_q    <= EQ;
      hold_q   <= '0;
      rem_q    <= '0;
      tick_q   <= 1'b0;
      cout_a_q <= 1'b0;
      cout_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      tgt_q    <= tgt_d;
      hold_q   <= hold_d;
      rem_q    <= rem_d;
      tick_q   <= tick_d;
      cout_a_q <= cout_a_d;
      cout_b_q <= cout_b_d;
    end
  end

  rel_tracker u_rel (
    .CLK   (CLK),
    .rst_n (rst_n),
    .inA   (cout_a_q),
    .inB   (cout_b_q),
    .AeqB  (bus.AeqB),
    .AmB   (bus.AmB),
    .BmA   (bus.BmA)
  );

  assign bus.CoutA = cout_a_q;
  assign bus.CoutB = cout_b_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_cout_pair_gen.sv
// Directed bench for cout_pair_gen; cycle 0 is the cycle right after the start edge.
module tb_cout_pair_gen;

  localparam logic [2:0] E = 3'b001;
  localparam logic [2:0] A = 3'b010;
  localparam logic [2:0] B = 3'b100;

  logic CLK;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  cout_pair_gen_if bus ();

  cout_pair_gen dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input bit ea, input bit eb,
                         input logic [2:0] er, input bit ebusy, input bit edone);
    chk({tag, ".CoutA"}, c, 32'(bus.CoutA), 32'(ea));
    chk({tag, ".CoutB"}, c, 32'(bus.CoutB), 32'(eb));
    chk({tag, ".rel"},   c, 32'({bus.BmA, bus.AmB, bus.AeqB}), 32'(er));
    chk({tag, ".busy"},  c, 32'(bus.busy), 32'(ebusy));
    chk({tag, ".done"},  c, 32'(bus.done), 32'(edone));
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_seq(input logic [1:0] t, input logic [9:0] p, input logic [7:0] h);
    bus.start    = 1'b1;
    bus.target   = t;
    bus.period   = p;
    bus.hold_cnt = h;
    next_cyc();
    bus.start    = 1'b0;
  endtask

  initial begin
    bus.start    = 1'b1;
    bus.target   = 2'b01;
    bus.period   = 10'd2;
    bus.hold_cnt = 8'd3;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_all("rst0", -1, 0, 0, E, 0, 0);
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      chk_all("rst", i, 0, 0, E, 0, 0);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    next_cyc();
    chk_all("idle", 0, 0, 0, E, 0, 0);

    // EQ -> A_LEAD, period 4, no hold pairs
    start_seq(2'b01, 10'd4, 8'd0);
    for (int c = 0; c <= 14; c++) begin
      chk_all("s1", c, c == 5, 0, (c >= 6) ? A : E, c <= 13, c == 13);
      next_cyc();
    end

    // A_LEAD -> B_LEAD takes two corrective pulses, then one hold pair
    start_seq(2'b10, 10'd2, 8'd1);
    for (int c = 0; c <= 12; c++) begin
      chk_all("s2", c, c == 9, (c == 3) || (c == 5) || (c == 9),
              (c < 4) ? A : ((c < 6) ? E : B), c <= 11, c == 11);
      next_cyc();
    end

    // period 0 clamps to 2; start re-pulsed during SEEK is ignored
    start_seq(2'b00, 10'd0, 8'd0);
    for (int c = 0; c <= 8; c++) begin
      chk_all("s3", c, c == 3, 0, (c < 4) ? B : E, c <= 7, c == 7);
      if (c == 1) begin
        bus.start    = 1'b1;
        bus.target   = 2'b01;
        bus.period   = 10'd7;
        bus.hold_cnt = 8'd9;
      end
      if (c == 3) bus.start = 1'b0;
      next_cyc();
    end

    // reset during HOLD with three pairs still owed
    start_seq(2'b01, 10'd2, 8'd5);
    for (int c = 0; c <= 9; c++) begin
      chk_all("s4", c, (c == 3) || (c == 7) || (c == 9), (c == 7) || (c == 9),
              (c < 4) ? E : A, 1, 0);
      next_cyc();
    end
    rst_n = 1'b0;
    bus.start = 1'b1;
    #1;
    chk_all("s4rst", 10, 0, 0, E, 0, 0);
    for (int c = 11; c <= 13; c++) begin
      next_cyc();
      chk_all("s4rst", c, 0, 0, E, 0, 0);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      chk_all("s4idle", c, 0, 0, E, 0, 0);
    end
    start_seq(2'b10, 10'd2, 8'd0);
    for (int c = 0; c <= 8; c++) begin
      chk_all("s4post", c, 0, c == 3, (c < 4) ? E : B, c <= 7, c == 7);
      next_cyc();
    end

    // target 11 behaves as EQ
    start_seq(2'b11, 10'd3, 8'd0);
    for (int c = 0; c <= 11; c++) begin
      chk_all("s5", c, c == 4, 0, (c < 5) ? B : E, c <= 10, c == 10);
      next_cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
